// File: rtl/md_ctrl.sv
// Multiply/divide controller for the E stage: owns HI/LO, runs a fixed-latency
// busy window per mult/div, and commits the result when the window closes.
module md_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cancel,
  output logic        Busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  md_op_e            op_q,    op_d;
  logic [31:0]       a_q,     a_d;
  logic [31:0]       b_q,     b_d;
  logic [31:0]       hi_q,    hi_d;
  logic [31:0]       lo_q,    lo_d;
  logic              done_q,  done_d;

  // Restoring unsigned divider; returns {remainder, quotient}.
  function automatic logic [63:0] udivmod(input logic [31:0] n, input logic [31:0] d);
    logic [32:0] rem;
    logic [31:0] quo;
    rem = '0;
    quo = n;
    for (int i = 0; i < 32; i++) begin
      rem = {rem[31:0], quo[31]};
      quo = {quo[30:0], 1'b0};
      if (rem >= {1'b0, d}) begin
        rem    = rem - {1'b0, d};
        quo[0] = 1'b1;
      end
    end
    return {rem[31:0], quo};
  endfunction

  logic        is_sdiv;
  logic [31:0] div_n, div_d;
  logic [63:0] div_raw;
  logic [31:0] quo_res, rem_res;
  logic [63:0] prod_u, prod_s;
  logic [63:0] result;
  logic        div_by_zero;

  // Signed division runs on magnitudes; signs are reapplied afterwards.
  always_comb begin
    is_sdiv = (op_q == OP_DIV);
    div_n   = (is_sdiv && a_q[31]) ? (~a_q + 32'd1) : a_q;
    div_d   = (is_sdiv && b_q[31]) ? (~b_q + 32'd1) : b_q;
    div_raw = udivmod(div_n, div_d);
    quo_res = (is_sdiv && (a_q[31] ^ b_q[31])) ? (~div_raw[31:0] + 32'd1) : div_raw[31:0];
    rem_res = (is_sdiv && a_q[31]) ? (~div_raw[63:32] + 32'd1) : div_raw[63:32];

    prod_u = {32'd0, a_q} * {32'd0, b_q};
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};

    div_by_zero = (op_q == OP_DIV || op_q == OP_DIVU) && (b_q == 32'd0);

    case (op_q)
      OP_MULT:          result = prod_s;
      OP_DIV, OP_DIVU:  result = {rem_res, quo_res};
      default:          result = prod_u;
    endcase
  end

  // NOTE: every _d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          case (MDOp)
            OP_MULT, OP_MULTU: begin
              op_d    = md_op_e'(MDOp);
              a_d     = A;
              b_d     = B;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = BUSY;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = md_op_e'(MDOp);
              a_d     = A;
              b_d     = B;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = BUSY;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      BUSY: begin
        // Issue requests here are stalled upstream and deliberately ignored.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (!div_by_zero) begin
            hi_d = result[63:32];
            lo_d = result[31:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign Busy = (state_q == BUSY);
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
